// File: rtl/sc_phase_generator_if.sv
// Two-phase switch-clock generator interface: run/length controls in, phases and status out.
// The master drives the controls; the generator (slave) drives the phase and status outputs.
interface sc_phase_generator_if #(
  parameter int CNT_W = 8
);
  logic             en;
  logic [CNT_W-1:0] phase_len;
  logic [CNT_W-1:0] dead_len;
  logic             phi1;
  logic             phi2;
  logic             running;
  logic             cycle_done;

  modport master (
    output en, phase_len, dead_len,
    input  phi1, phi2, running, cycle_done
  );

  modport slave (
    input  en, phase_len, dead_len,
    output phi1, phi2, running, cycle_done
  );
endinterface

// File: rtl/sc_phase_generator.sv
// Non-overlapping phi1/phi2 generator for switched-capacitor filters; phi1 rises the cycle after en is sampled.
// No backpressure: en is level-sensitive and a started period always runs to completion.
module sc_phase_generator #(
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  sc_phase_generator_if.slave    pg
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PH1   = 3'd1,
    DEAD1 = 3'd2,
    PH2   = 3'd3,
    DEAD2 = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           state;
  state_t           nxt_state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] nxt_cnt;
  logic [CNT_W-1:0] act_p;
  logic [CNT_W-1:0] act_d;
  logic [CNT_W-1:0] nxt_act_p;
  logic [CNT_W-1:0] nxt_act_d;
  logic [CNT_W-1:0] req_p;
  logic [CNT_W-1:0] req_d;
  logic             load;

  // Zero lengths are clamped to 1 so a phase or gap can never vanish.
  assign req_p = (pg.phase_len == '0) ? ONE : pg.phase_len;
  assign req_d = (pg.dead_len  == '0) ? ONE : pg.dead_len;

  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    nxt_act_p = act_p;
    nxt_act_d = act_d;
    load      = 1'b0;
    if (state != IDLE && cnt != '0) begin
      nxt_cnt = cnt - ONE;
    end else begin
      case (state)
        IDLE:  load = pg.en;
        PH1: begin
          nxt_state = DEAD1;
          nxt_cnt   = act_d - ONE;
        end
        DEAD1: begin
          nxt_state = PH2;
          nxt_cnt   = act_p - ONE;
        end
        PH2: begin
          nxt_state = DEAD2;
          nxt_cnt   = act_d - ONE;
        end
        DEAD2: begin
          if (pg.en) begin
            load = 1'b1;
          end else begin
            nxt_state = IDLE;
            nxt_cnt   = '0;
          end
        end
        default: begin
          nxt_state = IDLE;
          nxt_cnt   = '0;
        end
      endcase
    end
    // Shadow lengths are captured only at a period boundary.
    if (load) begin
      nxt_state = PH1;
      nxt_act_p = req_p;
      nxt_act_d = req_d;
      nxt_cnt   = req_p - ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      act_p         <= ONE;
      act_d         <= ONE;
      pg.phi1       <= 1'b0;
      pg.phi2       <= 1'b0;
      pg.running    <= 1'b0;
      pg.cycle_done <= 1'b0;
    end else begin
      state         <= nxt_state;
      cnt           <= nxt_cnt;
      act_p         <= nxt_act_p;
      act_d         <= nxt_act_d;
      // Outputs are decoded from the next state so they sit on flops aligned with the state.
      pg.phi1       <= (nxt_state == PH1);
      pg.phi2       <= (nxt_state == PH2);
      pg.running    <= (nxt_state != IDLE);
      pg.cycle_done <= (nxt_state == DEAD2) && (nxt_cnt == '0);
    end
  end

endmodule

// File: tb/tb_sc_phase_generator.sv
// Bench for sc_phase_generator: a queue of expected per-cycle outputs, built one whole period at a time.
module tb_sc_phase_generator;
  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  sc_phase_generator_if #(.CNT_W(CNT_W)) bus ();

  sc_phase_generator #(.CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .pg  (bus)
  );

  always #5 clk = ~clk;

  // Expected outputs per cycle, packed as {running, phi1, phi2, cycle_done}.
  logic [3:0] q[$];
  logic [3:0] exp_v;
  logic [3:0] obs;
  int         mdl_p = 1;
  int         run1 = 0;
  int         run2 = 0;
  int         pulse_len = 0;
  bit         pulse_end = 1'b0;

  task automatic push_period(input logic [CNT_W-1:0] p_in, input logic [CNT_W-1:0] d_in);
    int p;
    int d;
    p = (p_in == 0) ? 1 : int'(p_in);
    d = (d_in == 0) ? 1 : int'(d_in);
    mdl_p = p;
    repeat (p)     q.push_back(4'b1100);
    repeat (d)     q.push_back(4'b1000);
    repeat (p)     q.push_back(4'b1010);
    repeat (d - 1) q.push_back(4'b1000);
    q.push_back(4'b1001);
  endtask

  // Advance one clock: update the model with the values sampled at the edge, then observe.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      q.delete();
    end else begin
      if (q.size() > 0) void'(q.pop_front());
      if (q.size() == 0 && bus.en) push_period(bus.phase_len, bus.dead_len);
    end
    #1;
    exp_v = (q.size() > 0) ? q[0] : 4'b0000;
    obs   = {bus.running, bus.phi1, bus.phi2, bus.cycle_done};
    pulse_end = 1'b0;
    if (bus.phi1) run1++;
    else begin
      if (run1 > 0) begin pulse_end = 1'b1; pulse_len = run1; end
      run1 = 0;
    end
    if (bus.phi2) run2++;
    else begin
      if (run2 > 0) begin pulse_end = 1'b1; pulse_len = run2; end
      run2 = 0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.en = 1'b0;
    bus.phase_len = '0;
    bus.dead_len = '0;
    #1;
    checks++;
    if ({bus.running, bus.phi1, bus.phi2, bus.cycle_done} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_initial got %b want 0000", {bus.running, bus.phi1, bus.phi2, bus.cycle_done});
    end
    bus.en = 1'b1;
    bus.phase_len = 8'd3;
    bus.dead_len = 8'd1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (obs !== 4'b0000) begin
        errors++;
        $display("FAIL reset_held cyc %0d got %b want 0000", i, obs);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    bus.en = 1'b0;
    tick();
    checks++;
    if (obs !== 4'b0000) begin
      errors++;
      $display("FAIL reset_idle got %b want 0000", obs);
    end
  endtask

  task automatic test_basic();
    int cd_count;
    cd_count = 0;
    @(negedge clk);
    bus.phase_len = 8'd3;
    bus.dead_len = 8'd1;
    bus.en = 1'b1;
    for (int i = 0; i < 24; i++) begin
      tick();
      if (obs[0]) cd_count++;
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL basic cyc %0d got %b want %b", i, obs, exp_v);
      end
      checks++;
      if ((bus.phi1 & bus.phi2) !== 1'b0) begin
        errors++;
        $display("FAIL basic_overlap cyc %0d got 1 want 0", i);
      end
      if (pulse_end) begin
        checks++;
        if (pulse_len !== mdl_p) begin
          errors++;
          $display("FAIL basic_pulse got %0d want %0d", pulse_len, mdl_p);
        end
      end
    end
    checks++;
    if (cd_count !== 3) begin
      errors++;
      $display("FAIL basic_cycle_done_count got %0d want 3", cd_count);
    end
  endtask

  task automatic test_zero_len();
    @(negedge clk);
    bus.phase_len = 8'd0;
    bus.dead_len = 8'd0;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL zero_len cyc %0d got %b want %b", i, obs, exp_v);
      end
      checks++;
      if ((bus.phi1 & bus.phi2) !== 1'b0) begin
        errors++;
        $display("FAIL zero_overlap cyc %0d got 1 want 0", i);
      end
      if (pulse_end) begin
        checks++;
        if (pulse_len !== mdl_p) begin
          errors++;
          $display("FAIL zero_pulse got %0d want %0d", pulse_len, mdl_p);
        end
      end
    end
  endtask

  task automatic test_stop_mid_period();
    int run_cycles;
    int budget;
    @(negedge clk);
    bus.en = 1'b0;
    budget = 0;
    do begin
      tick();
      budget++;
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL stop_drain got %b want %b", obs, exp_v);
      end
    end while (q.size() > 0 && budget < 60);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL stop_drain_timeout got %0d queued want 0", q.size());
    end
    @(negedge clk);
    bus.phase_len = 8'd4;
    bus.dead_len = 8'd2;
    bus.en = 1'b1;
    run_cycles = 0;
    tick();
    if (bus.running) run_cycles++;
    tick();
    if (bus.running) run_cycles++;
    @(negedge clk);
    bus.en = 1'b0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (bus.running) run_cycles++;
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL stop cyc %0d got %b want %b", i, obs, exp_v);
      end
      if (pulse_end) begin
        checks++;
        if (pulse_len !== 4) begin
          errors++;
          $display("FAIL stop_pulse got %0d want 4", pulse_len);
        end
      end
    end
    checks++;
    if (run_cycles !== 12) begin
      errors++;
      $display("FAIL stop_running_cycles got %0d want 12", run_cycles);
    end
  endtask

  task automatic test_reconfig();
    int first_p1;
    first_p1 = -1;
    @(negedge clk);
    bus.phase_len = 8'd2;
    bus.dead_len = 8'd1;
    bus.en = 1'b1;
    repeat (4) tick();
    checks++;
    if (bus.phi2 !== 1'b1) begin
      errors++;
      $display("FAIL reconfig_in_ph2 got %b want 1", bus.phi2);
    end
    @(negedge clk);
    bus.phase_len = 8'd5;
    for (int i = 0; i < 24; i++) begin
      tick();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL reconfig cyc %0d got %b want %b", i, obs, exp_v);
      end
      if (pulse_end) begin
        if (first_p1 < 0 && pulse_len != 2) first_p1 = pulse_len;
        checks++;
        if (pulse_len !== mdl_p) begin
          errors++;
          $display("FAIL reconfig_pulse got %0d want %0d", pulse_len, mdl_p);
        end
      end
    end
    checks++;
    if (first_p1 !== 5) begin
      errors++;
      $display("FAIL reconfig_new_phi1 got %0d want 5", first_p1);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) bus.en = ~bus.en;
      if ($urandom_range(0, 9) == 0) bus.phase_len = CNT_W'($urandom_range(0, 5));
      if ($urandom_range(0, 9) == 0) bus.dead_len = CNT_W'($urandom_range(0, 3));
      tick();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL random cyc %0d got %b want %b", i, obs, exp_v);
      end
      checks++;
      if ((bus.phi1 & bus.phi2) !== 1'b0) begin
        errors++;
        $display("FAIL random_overlap cyc %0d got 1 want 0", i);
      end
      if (pulse_end) begin
        checks++;
        if (pulse_len !== mdl_p) begin
          errors++;
          $display("FAIL random_pulse got %0d want %0d", pulse_len, mdl_p);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    int budget;
    @(negedge clk);
    bus.phase_len = 8'd3;
    bus.dead_len = 8'd2;
    bus.en = 1'b1;
    budget = 0;
    do begin
      tick();
      budget++;
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL areset_pre got %b want %b", obs, exp_v);
      end
    end while (bus.phi2 !== 1'b1 && budget < 60);
    checks++;
    if (bus.phi2 !== 1'b1) begin
      errors++;
      $display("FAIL areset_wait_phi2 got %b want 1", bus.phi2);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.running, bus.phi1, bus.phi2, bus.cycle_done} !== 4'b0000) begin
      errors++;
      $display("FAIL areset_immediate got %b want 0000", {bus.running, bus.phi1, bus.phi2, bus.cycle_done});
    end
    q.delete();
    run1 = 0;
    run2 = 0;
    repeat (2) tick();
    @(negedge clk);
    rst = 1'b0;
    tick();
    checks++;
    if (bus.phi1 !== 1'b1) begin
      errors++;
      $display("FAIL areset_first_phi1 got %b want 1", bus.phi1);
    end
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL areset_post cyc %0d got %b want %b", i, obs, exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_stop_mid_period();
    test_reconfig();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sc_phase_generator.md
SC_PHASE_GENERATOR -- requirements
Module: sc_phase_generator

Interface
REQ-001 The module SHALL have parameter CNT_W, default 8, giving the width of the phase and dead-time length fields.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all flops are on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: the reset; already decided as asynchronous and active-high.
REQ-004 The module SHALL have port en, input, 1 bit: run request, level-sensitive.
REQ-005 The module SHALL have port phase_len, input, CNT_W bits: the width in clk cycles of each of phi1 and phi2.
REQ-006 The module SHALL have port dead_len, input, CNT_W bits: the non-overlap gap in clk cycles after each phase.
REQ-007 The module SHALL have port phi1, output, 1 bit: switch clock for the sampling phase of the switched-capacitor filter.
REQ-008 The module SHALL have port phi2, output, 1 bit: switch clock for the charge-transfer phase of the switched-capacitor filter.
REQ-009 The module SHALL have port running, output, 1 bit: high while the FSM is not in IDLE.
REQ-010 The module SHALL have port cycle_done, output, 1 bit: one-cycle pulse on the last cycle of each full period.

Function
REQ-011 The FSM SHALL have the states IDLE, PH1, DEAD1, PH2 and DEAD2, with one down-counter of CNT_W bits.
REQ-012 The module SHALL register shadow values act_p = max(phase_len,1) and act_d = max(dead_len,1); a zero length is treated as 1.
REQ-013 Shadow values SHALL load only on the IDLE->PH1 transition and on the DEAD2->PH1 transition; input changes at any other time SHALL NOT alter the period in progress.
REQ-014 In IDLE with en=1 at a clk edge, the FSM SHALL move to PH1 at that edge; phi1 is therefore high in the first cycle after en is sampled.
REQ-015 Each state PH1, DEAD1, PH2 and DEAD2 SHALL last exactly act_p, act_d, act_p and act_d cycles respectively; the counter loads length-1 on entry and the state exits when the counter is 0.
REQ-016 The full period SHALL be 2*act_p + 2*act_d cycles.
REQ-017 phi1 SHALL be 1 exactly in cycles where the state is PH1, and phi2 exactly in cycles where the state is PH2; both are driven straight from flops, with no combinational output path.
REQ-018 phi1 and phi2 SHALL never be high in the same cycle, and at least act_d (at least 1) low-low cycles SHALL separate any phi1 edge from any phi2 edge, including across start, stop and reconfiguration.
REQ-019 cycle_done SHALL be 1 in the final DEAD2 cycle only.
REQ-020 At the end of DEAD2, the FSM SHALL go to PH1 if en=1 and to IDLE if en=0.
REQ-021 Deasserting en mid-period SHALL NOT truncate the period: the FSM completes through DEAD2, so no runt phase pulse is produced.
REQ-022 Reasserting en before DEAD2 ends SHALL continue seamlessly; no gap beyond act_d is inserted.
REQ-023 running SHALL be 1 in every non-IDLE state, including the final DEAD2 cycle of a stop.
REQ-024 Counter and lengths SHALL be unsigned, and no wrap SHALL occur, because the counter never decrements below 0.

Reset
REQ-025 On rst=1 the module SHALL immediately and asynchronously force state=IDLE, counter=0, act_p=1, act_d=1, phi1=0, phi2=0, running=0 and cycle_done=0.
REQ-026 When rst asserts mid-phase, both phases SHALL drop at once, with no pulse completion.
REQ-027 After rst deasserts, the first possible phi1 SHALL be the cycle after the first edge that samples en=1.

Verification
REQ-028 Basic run: phase_len=3, dead_len=1, en=1 held -> phi1 is high for 3 cycles, then 1 low cycle, then phi2 high for 3 cycles, then 1 low cycle, giving a period of 8 cycles; cycle_done pulses every 8 cycles.
REQ-029 Zero lengths: phase_len=0, dead_len=0 -> the output repeats the pattern phi1, gap, phi2, gap every 4 cycles; phi1 & phi2 is never 1.
REQ-030 Stop mid-period: en drops during the 2nd cycle of PH1 with phase_len=4, dead_len=2 -> the period completes (12 cycles total), then IDLE; running falls after the cycle_done cycle.
REQ-031 Reconfiguration: phase_len changes from 2 to 5 during PH2 -> the current period keeps act_p=2, and the next period shows phi1 high for 5 cycles.
REQ-032 Asynchronous reset: rst asserted during phi2 high, between clk edges -> phi2=0 and running=0 before the next edge; after release with en=1, phi1 rises the cycle after the first sampled edge.
REQ-033 Continuous checker on every test: phi1 and phi2 are never both high, and no phase pulse is shorter than act_p.
